// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_rd_arbiter : round-robin, burst-limited read arbiter for switch FIFOs
// Revision 1.0 - initial release
// ============================================================================
module fifo_rd_arbiter #(
  parameter int NUM_SW_INST = 5,
  parameter int MAX_BURST   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SW_INST-1:0]         fifo_empty,
  output logic [NUM_SW_INST-1:0]         fifo_rd_en,
  output logic [NUM_SW_INST-1:0]         rd_sel,
  output logic                           frame_valid,
  input  logic                           out_ready,
  output logic [$clog2(NUM_SW_INST)-1:0] cur_src,
  output logic [CNT_WIDTH-1:0]           frame_cnt
);

  localparam int SW = $clog2(NUM_SW_INST);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [SW-1:0]          cur_src_q, cur_src_d;
  logic [SW-1:0]          last_grant_q, last_grant_d;
  logic [NUM_SW_INST-1:0] rd_sel_q, rd_sel_d;
  logic [BW-1:0]          burst_q, burst_d;
  logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;

  logic                   found;
  logic [SW-1:0]          pick;
  logic [SW-1:0]          idx;

  // First non-empty FIFO scanning upward from the one after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_SW_INST; k++) begin
      idx = SW'((int'(last_grant_q) + k) % NUM_SW_INST);
      if (!found && !fifo_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    last_grant_d = last_grant_q;
    rd_sel_d     = rd_sel_q;
    burst_d      = burst_q;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          cur_src_d = pick;
          rd_sel_d  = NUM_SW_INST'(1) << pick;
          state_d   = ST_READ;
        end
      end
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_HOLD;
      ST_HOLD: begin
        if (out_ready) begin
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          if ((int'(burst_q) + 1 < MAX_BURST) && !fifo_empty[cur_src_q]) begin
            burst_d = burst_q + BW'(1);
            state_d = ST_READ;
          end else begin
            burst_d      = '0;
            last_grant_d = cur_src_q;
            rd_sel_d     = '0;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_src_q    <= '0;
      last_grant_q <= SW'(NUM_SW_INST - 1);
      rd_sel_q     <= '0;
      burst_q      <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      last_grant_q <= last_grant_d;
      rd_sel_q     <= rd_sel_d;
      burst_q      <= burst_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign fifo_rd_en  = (state_q == ST_READ) ? rd_sel_q : '0;
  assign frame_valid = (state_q == ST_HOLD);
  assign rd_sel      = rd_sel_q;
  assign cur_src     = cur_src_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
